// File: rtl/pll_seq_ctl.sv
// ---------------------------------------------------------------------------
// pll_seq_ctl
//
// Power-up and relock sequencer for the on-chip clock PLL. Runs entirely in
// the PLL reference-clock domain. Holds the PLL in standby while the divider
// settings are loaded, waits for a stable lock, opens the downstream clock
// gate and then releases core reset. While running it supervises lock and
// relocks automatically when lock is lost.
//
// Ports:
//   clk          PLL reference clock
//   reset_l      asynchronous active-low reset
//   start        pulse: begin sequencing from IDLE or FAIL
//   relock       pulse: force a relock from RUN
//   cfg_m0       requested M divider
//   cfg_n/pa/pb/pc  requested N and port A/B/C dividers (4 bits each)
//   plock        PLL lock indicator (asynchronous, synchronised here)
//   err_clr      clears the sticky error flags
//   pll_stby     PLL STBY pin
//   pll_m0       PLL M0 pin
//   pll_n/pa/pb/pc  PLL divider pins (4 bits each)
//   clk_en       downstream clock-gate enable
//   core_rst_l   core reset, active low
//   state        current sequencer state
//   timeout_err  sticky: lock not achieved within LOCK_TIMEOUT clocks
//   lock_err     sticky: lock lost in ENABLE or RUN
//
// Build option:
//   PLL_SEQ_CTL_RETRY_EN  when defined, a lock timeout returns to STBY and
//                         retries up to 3 times before entering FAIL.
// ---------------------------------------------------------------------------
module pll_seq_ctl #(
    parameter int unsigned STBY_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned RST_DLY       = 8,
    parameter logic [3:0]  DEF_N         = 4'd7,
    parameter logic        DEF_M0        = 1'b1,
    parameter logic [3:0]  DEF_PA        = 4'd1,
    parameter logic [3:0]  DEF_PB        = 4'd1,
    parameter logic [3:0]  DEF_PC        = 4'd1
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       start,
    input  logic       relock,
    input  logic       cfg_m0,
    input  logic [3:0] cfg_n,
    input  logic [3:0] cfg_pa,
    input  logic [3:0] cfg_pb,
    input  logic [3:0] cfg_pc,
    input  logic       plock,
    input  logic       err_clr,
    output logic       pll_stby,
    output logic       pll_m0,
    output logic [3:0] pll_n,
    output logic [3:0] pll_pa,
    output logic [3:0] pll_pb,
    output logic [3:0] pll_pc,
    output logic       clk_en,
    output logic       core_rst_l,
    output logic [2:0] state,
    output logic       timeout_err,
    output logic       lock_err
);

    localparam int unsigned SBW = $clog2(STBY_CYCLES + 1);
    localparam int unsigned TOW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned STW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned RDW = $clog2(RST_DLY + 1);

    localparam logic [SBW-1:0] SB_LAST = SBW'(STBY_CYCLES - 1);
    localparam logic [SBW-1:0] SB_MAX  = SBW'(STBY_CYCLES);
    localparam logic [TOW-1:0] TO_LAST = TOW'(LOCK_TIMEOUT - 1);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(LOCK_TIMEOUT);
    localparam logic [STW-1:0] ST_LAST = STW'(SETTLE_CYCLES - 1);
    localparam logic [STW-1:0] ST_MAX  = STW'(SETTLE_CYCLES);
    localparam logic [RDW-1:0] RD_LAST = RDW'(RST_DLY - 1);
    localparam logic [RDW-1:0] RD_MAX  = RDW'(RST_DLY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STBY   = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_ENABLE = 3'd4,
        S_RUN    = 3'd5,
        S_FAIL   = 3'd6
    } state_e;

    state_e         state_q, state_d;
    logic           plock_meta_q, plock_s_q;
    logic [SBW-1:0] sb_cnt_q, sb_cnt_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [STW-1:0] st_cnt_q, st_cnt_d;
    logic [RDW-1:0] rd_cnt_q, rd_cnt_d;
    logic           pll_stby_q, pll_stby_d;
    logic           pll_m0_q, pll_m0_d;
    logic [3:0]     pll_n_q, pll_n_d;
    logic [3:0]     pll_pa_q, pll_pa_d;
    logic [3:0]     pll_pb_q, pll_pb_d;
    logic [3:0]     pll_pc_q, pll_pc_d;
    logic           clk_en_q, clk_en_d;
    logic           core_rst_l_q, core_rst_l_d;
    logic           timeout_err_q, timeout_err_d;
    logic           lock_err_q, lock_err_d;
    logic           to_fire;
    logic           set_to;
    logic           set_lock;
    logic           retry_exhausted;
    logic           entering;

    // Two-flop synchroniser for the asynchronous lock indicator.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            plock_meta_q <= 1'b0;
            plock_s_q    <= 1'b0;
        end else begin
            plock_meta_q <= plock;
            plock_s_q    <= plock_meta_q;
        end
    end

`ifdef PLL_SEQ_CTL_RETRY_EN
    logic [1:0] retry_q, retry_d;

    assign retry_exhausted = (retry_q == 2'd3);

    always_comb begin
        retry_d = retry_q;
        if ((state_d == S_RUN) ||
            (((state_q == S_IDLE) || (state_q == S_FAIL)) && start)) begin
            retry_d = '0;
        end else if (to_fire && !retry_exhausted) begin
            retry_d = retry_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    assign retry_exhausted = 1'b1;
`endif

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        to_fire  = 1'b0;
        set_to   = 1'b0;
        set_lock = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_STBY;
            end
            S_STBY: begin
                if (sb_cnt_q >= SB_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (plock_s_q)                  state_d = S_SETTLE;
                else if (to_cnt_q >= TO_LAST)   to_fire = 1'b1;
            end
            S_SETTLE: begin
                // Timeout keeps running here; a lock drop resumes WAIT
                // without restarting the timeout window.
                if (!plock_s_q)                 state_d = S_WAIT;
                else if (st_cnt_q >= ST_LAST)   state_d = S_ENABLE;
                else if (to_cnt_q >= TO_LAST)   to_fire = 1'b1;
            end
            S_ENABLE: begin
                if (!plock_s_q) begin
                    set_lock = 1'b1;
                    state_d  = S_STBY;
                end else if (rd_cnt_q >= RD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!plock_s_q) set_lock = 1'b1;
                if (!plock_s_q || relock) state_d = S_STBY;
            end
            S_FAIL: begin
                if (start) state_d = S_STBY;
            end
            default: state_d = S_IDLE;
        endcase

        if (to_fire) begin
            if (retry_exhausted) begin
                state_d = S_FAIL;
                set_to  = 1'b1;
            end else begin
                state_d = S_STBY;
            end
        end
    end

    // Phase counters clear on every state entry; the timeout counter only
    // restarts when a fresh lock attempt begins (STBY -> WAIT).
    always_comb begin
        entering = (state_d != state_q);
        sb_cnt_d = sb_cnt_q;
        st_cnt_d = st_cnt_q;
        rd_cnt_d = rd_cnt_q;
        to_cnt_d = to_cnt_q;

        if (entering) begin
            sb_cnt_d = '0;
            st_cnt_d = '0;
            rd_cnt_d = '0;
        end else begin
            if ((state_q == S_STBY) && (sb_cnt_q < SB_MAX))
                sb_cnt_d = sb_cnt_q + SBW'(1);
            if ((state_q == S_SETTLE) && (st_cnt_q < ST_MAX))
                st_cnt_d = st_cnt_q + STW'(1);
            if ((state_q == S_ENABLE) && (rd_cnt_q < RD_MAX))
                rd_cnt_d = rd_cnt_q + RDW'(1);
        end

        if ((state_q == S_STBY) && (state_d == S_WAIT)) begin
            to_cnt_d = '0;
        end else if (((state_q == S_WAIT) || (state_q == S_SETTLE)) &&
                     (to_cnt_q < TO_MAX)) begin
            to_cnt_d = to_cnt_q + TOW'(1);
        end
    end

    // Outputs are registered from the next state so every pin changes on
    // the same edge as the state it belongs to.
    always_comb begin
        pll_stby_d   = !(state_d inside {S_WAIT, S_SETTLE, S_ENABLE, S_RUN});
        clk_en_d     = (state_d inside {S_ENABLE, S_RUN});
        core_rst_l_d = (state_d == S_RUN);
        pll_m0_d     = pll_m0_q;
        pll_n_d      = pll_n_q;
        pll_pa_d     = pll_pa_q;
        pll_pb_d     = pll_pb_q;
        pll_pc_d     = pll_pc_q;
        if ((state_d == S_STBY) && (state_q != S_STBY)) begin
            pll_m0_d = cfg_m0;
            pll_n_d  = cfg_n;
            pll_pa_d = cfg_pa;
            pll_pb_d = cfg_pb;
            pll_pc_d = cfg_pc;
        end
        // A new error on the same edge as err_clr leaves the flag set.
        timeout_err_d = set_to   | (timeout_err_q & ~err_clr);
        lock_err_d    = set_lock | (lock_err_q    & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= S_IDLE;
            sb_cnt_q      <= '0;
            to_cnt_q      <= '0;
            st_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            pll_stby_q    <= 1'b1;
            pll_m0_q      <= DEF_M0;
            pll_n_q       <= DEF_N;
            pll_pa_q      <= DEF_PA;
            pll_pb_q      <= DEF_PB;
            pll_pc_q      <= DEF_PC;
            clk_en_q      <= 1'b0;
            core_rst_l_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            lock_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sb_cnt_q      <= sb_cnt_d;
            to_cnt_q      <= to_cnt_d;
            st_cnt_q      <= st_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            pll_stby_q    <= pll_stby_d;
            pll_m0_q      <= pll_m0_d;
            pll_n_q       <= pll_n_d;
            pll_pa_q      <= pll_pa_d;
            pll_pb_q      <= pll_pb_d;
            pll_pc_q      <= pll_pc_d;
            clk_en_q      <= clk_en_d;
            core_rst_l_q  <= core_rst_l_d;
            timeout_err_q <= timeout_err_d;
            lock_err_q    <= lock_err_d;
        end
    end

    assign pll_stby    = pll_stby_q;
    assign pll_m0      = pll_m0_q;
    assign pll_n       = pll_n_q;
    assign pll_pa      = pll_pa_q;
    assign pll_pb      = pll_pb_q;
    assign pll_pc      = pll_pc_q;
    assign clk_en      = clk_en_q;
    assign core_rst_l  = core_rst_l_q;
    assign state       = state_q;
    assign timeout_err = timeout_err_q;
    assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_pll_seq_ctl.sv
// ---------------------------------------------------------------------------
// tb_pll_seq_ctl
//
// Self-checking bench for pll_seq_ctl. Expected behaviour is expressed as
// event latencies derived from the sequencer parameters (how many clocks
// each phase lasts) plus expected pin values in each phase. Inputs are
// driven 1 ns after the rising edge; outputs are observed at that point too,
// so they reflect the edge just taken.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_seq_ctl;

    localparam int STBY_CYCLES   = 16;
    localparam int LOCK_TIMEOUT  = 4096;
    localparam int SETTLE_CYCLES = 256;
    localparam int RST_DLY       = 8;
    localparam int SYNC_STAGES   = 2;
`ifdef PLL_SEQ_CTL_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif
    // plock driven just after an edge is first sampled on the next edge and
    // then needs SYNC_STAGES more edges before the sequencer acts on it.
    localparam int LOCK_REACT = SYNC_STAGES + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STBY   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_ENABLE = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_FAIL   = 3'd6;

    // {stby, m0, n, pa, pb, pc, clk_en, core_rst_l, state, timeout_err, lock_err}
    localparam logic [24:0] RESET_SNAP =
        {1'b1, 1'b1, 4'd7, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       reset_l, start, relock, cfg_m0, plock, err_clr;
    logic [3:0] cfg_n, cfg_pa, cfg_pb, cfg_pc;
    logic       pll_stby, pll_m0, clk_en, core_rst_l, timeout_err, lock_err;
    logic [3:0] pll_n, pll_pa, pll_pb, pll_pc;
    logic [2:0] state;
    logic [24:0] snap;
    logic [16:0] exp_div;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign snap = {pll_stby, pll_m0, pll_n, pll_pa, pll_pb, pll_pc,
                   clk_en, core_rst_l, state, timeout_err, lock_err};

    pll_seq_ctl #(
        .STBY_CYCLES   (STBY_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .RST_DLY       (RST_DLY)
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .start       (start),
        .relock      (relock),
        .cfg_m0      (cfg_m0),
        .cfg_n       (cfg_n),
        .cfg_pa      (cfg_pa),
        .cfg_pb      (cfg_pb),
        .cfg_pc      (cfg_pc),
        .plock       (plock),
        .err_clr     (err_clr),
        .pll_stby    (pll_stby),
        .pll_m0      (pll_m0),
        .pll_n       (pll_n),
        .pll_pa      (pll_pa),
        .pll_pb      (pll_pb),
        .pll_pc      (pll_pc),
        .clk_en      (clk_en),
        .core_rst_l  (core_rst_l),
        .state       (state),
        .timeout_err (timeout_err),
        .lock_err    (lock_err)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait; n = clocks taken, or -1 if the state never appeared.
    task automatic wait_state(input logic [2:0] st, input int budget, output int n);
        n = 0;
        while (state !== st && n < budget) begin
            step(1);
            n++;
        end
        if (state !== st) n = -1;
    endtask

    task automatic apply_reset();
        reset_l = 1'b0;
        start   = 1'b0;
        relock  = 1'b0;
        plock   = 1'b0;
        err_clr = 1'b0;
        step(2);
        reset_l = 1'b1;
        step(1);
    endtask

    task automatic rand_cfg();
        cfg_m0 = 1'($urandom_range(0, 1));
        cfg_n  = 4'($urandom_range(0, 15));
        cfg_pa = 4'($urandom_range(0, 15));
        cfg_pb = 4'($urandom_range(0, 15));
        cfg_pc = 4'($urandom_range(0, 15));
        exp_div = {cfg_m0, cfg_n, cfg_pa, cfg_pb, cfg_pc};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Stimulus only: start, lock as soon as WAIT is reached, run to RUN.
    task automatic bring_to_run();
        int n;
        pulse_start();
        wait_state(ST_WAIT, 100, n);
        plock = 1'b1;
        wait_state(ST_RUN, 1000, n);
    endtask

    task automatic test_reset();
        int n;
        reset_l = 1'b0; start = 1'b0; relock = 1'b0; plock = 1'b0; err_clr = 1'b0;
        cfg_m0 = 1'b0; cfg_n = 4'd3; cfg_pa = 4'd2; cfg_pb = 4'd2; cfg_pc = 4'd2;
        step(3);
        tests_run++;
        if (snap !== RESET_SNAP) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", snap, RESET_SNAP);
        end
        reset_l = 1'b1;
        relock  = 1'b1;
        step(1);
        relock  = 1'b0;
        step(3);
        tests_run++;
        if (snap !== RESET_SNAP) begin
            tests_failed++;
            $display("FAIL idle_holds: got %h expected %h", snap, RESET_SNAP);
        end
    endtask

    task automatic test_bringup();
        int n;
        apply_reset();
        rand_cfg();
        cfg_n = 4'd7;
        exp_div = {cfg_m0, cfg_n, cfg_pa, cfg_pb, cfg_pc};
        pulse_start();
        tests_run++;
        if (state !== ST_STBY || pll_stby !== 1'b1 ||
            {pll_m0, pll_n, pll_pa, pll_pb, pll_pc} !== exp_div) begin
            tests_failed++;
            $display("FAIL bringup_stby_entry: state=%0d stby=%b div=%h expected state=%0d stby=1 div=%h",
                     state, pll_stby, {pll_m0, pll_n, pll_pa, pll_pb, pll_pc}, ST_STBY, exp_div);
        end
        wait_state(ST_WAIT, 100, n);
        tests_run++;
        if (n !== STBY_CYCLES || pll_stby !== 1'b0) begin
            tests_failed++;
            $display("FAIL bringup_stby_len: got %0d clocks stby=%b expected %0d clocks stby=0",
                     n, pll_stby, STBY_CYCLES);
        end
        step(99);
        plock = 1'b1;
        wait_state(ST_SETTLE, 20, n);
        tests_run++;
        if (n !== LOCK_REACT) begin
            tests_failed++;
            $display("FAIL bringup_settle_lat: got %0d expected %0d", n, LOCK_REACT);
        end
        wait_state(ST_ENABLE, 400, n);
        tests_run++;
        if (n !== SETTLE_CYCLES || clk_en !== 1'b1 || core_rst_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL bringup_clk_en: got %0d clocks clk_en=%b rst_l=%b expected %0d clocks clk_en=1 rst_l=0",
                     n, clk_en, core_rst_l, SETTLE_CYCLES);
        end
        wait_state(ST_RUN, 50, n);
        tests_run++;
        if (n !== RST_DLY || {clk_en, core_rst_l, pll_stby} !== 3'b110) begin
            tests_failed++;
            $display("FAIL bringup_run: got %0d clocks en/rst/stby=%b expected %0d clocks 110",
                     n, {clk_en, core_rst_l, pll_stby}, RST_DLY);
        end
    endtask

    task automatic test_settle_glitch();
        int n;
        apply_reset();
        rand_cfg();
        pulse_start();
        wait_state(ST_WAIT, 100, n);
        plock = 1'b1;
        wait_state(ST_SETTLE, 20, n);
        step(100);
        plock = 1'b0;
        step(LOCK_REACT - 1);
        tests_run++;
        if (state !== ST_SETTLE) begin
            tests_failed++;
            $display("FAIL glitch_before_react: state=%0d expected %0d", state, ST_SETTLE);
        end
        step(1);
        tests_run++;
        if (state !== ST_WAIT || clk_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_back_to_wait: state=%0d clk_en=%b expected %0d 0", state, clk_en, ST_WAIT);
        end
        plock = 1'b1;
        wait_state(ST_SETTLE, 20, n);
        tests_run++;
        if (n !== LOCK_REACT) begin
            tests_failed++;
            $display("FAIL glitch_resettle_lat: got %0d expected %0d", n, LOCK_REACT);
        end
        wait_state(ST_ENABLE, 400, n);
        tests_run++;
        if (n !== SETTLE_CYCLES || clk_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_settle_restart: got %0d clk_en=%b expected %0d 1", n, clk_en, SETTLE_CYCLES);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [2:0] exp_st;
        apply_reset();
        rand_cfg();
        pulse_start();
        wait_state(ST_WAIT, 100, n);
        for (int pass = 0; pass <= RETRIES; pass++) begin
            step(LOCK_TIMEOUT - 1);
            tests_run++;
            if (state !== ST_WAIT || timeout_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_early pass %0d: state=%0d err=%b expected %0d 0",
                         pass, state, timeout_err, ST_WAIT);
            end
            step(1);
            exp_st = (pass == RETRIES) ? ST_FAIL : ST_STBY;
            tests_run++;
            if (state !== exp_st || pll_stby !== 1'b1 || timeout_err !== (pass == RETRIES)) begin
                tests_failed++;
                $display("FAIL timeout_expiry pass %0d: state=%0d stby=%b err=%b expected %0d 1 %b",
                         pass, state, pll_stby, timeout_err, exp_st, pass == RETRIES);
            end
            if (pass < RETRIES) begin
                step(STBY_CYCLES);
                tests_run++;
                if (state !== ST_WAIT) begin
                    tests_failed++;
                    $display("FAIL timeout_retry_wait pass %0d: state=%0d expected %0d", pass, state, ST_WAIT);
                end
            end
        end
        tests_run++;
        if ({clk_en, core_rst_l} !== 2'b00) begin
            tests_failed++;
            $display("FAIL fail_outputs: en/rst=%b expected 00", {clk_en, core_rst_l});
        end
        pulse_start();
        tests_run++;
        if (state !== ST_STBY || timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL fail_restart: state=%0d err=%b expected %0d 1", state, timeout_err, ST_STBY);
        end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_lock_loss_run();
        int n;
        apply_reset();
        rand_cfg();
        bring_to_run();
        tests_run++;
        if (state !== ST_RUN) begin
            tests_failed++;
            $display("FAIL lossrun_reach_run: state=%0d expected %0d", state, ST_RUN);
        end
        plock = 1'b0;
        step(LOCK_REACT - 1);
        tests_run++;
        if (state !== ST_RUN || lock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL lossrun_early: state=%0d lock_err=%b expected %0d 0", state, lock_err, ST_RUN);
        end
        step(1);
        tests_run++;
        if ({clk_en, core_rst_l, pll_stby, lock_err, state} !== {4'b0011, ST_STBY}) begin
            tests_failed++;
            $display("FAIL lossrun_exit: en/rst/stby/err/state=%b expected %b",
                     {clk_en, core_rst_l, pll_stby, lock_err, state}, {4'b0011, ST_STBY});
        end
        plock = 1'b1;
        wait_state(ST_RUN, 1000, n);
        tests_run++;
        if (n !== STBY_CYCLES + 1 + SETTLE_CYCLES + RST_DLY || lock_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL lossrun_relock: got %0d clocks lock_err=%b expected %0d clocks 1",
                     n, lock_err, STBY_CYCLES + 1 + SETTLE_CYCLES + RST_DLY);
        end
    endtask

    task automatic test_relock_cfg();
        int n;
        apply_reset();
        rand_cfg();
        cfg_n = 4'd7;
        bring_to_run();
        cfg_n = 4'd5;
        step(3);
        tests_run++;
        if (pll_n !== 4'd7 || state !== ST_RUN) begin
            tests_failed++;
            $display("FAIL relock_hold_n: pll_n=%0d state=%0d expected 7 %0d", pll_n, state, ST_RUN);
        end
        relock = 1'b1;
        step(1);
        relock = 1'b0;
        tests_run++;
        if (state !== ST_STBY || pll_n !== 4'd5) begin
            tests_failed++;
            $display("FAIL relock_entry: state=%0d pll_n=%0d expected %0d 5", state, pll_n, ST_STBY);
        end
        cfg_n = 4'd3;
        step(2);
        tests_run++;
        if (pll_n !== 4'd5) begin
            tests_failed++;
            $display("FAIL relock_latch_once: pll_n=%0d expected 5", pll_n);
        end
        wait_state(ST_RUN, 1000, n);
        plock = 1'b0;
        step(LOCK_REACT - 1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        tests_run++;
        if (lock_err !== 1'b1 || state !== ST_STBY) begin
            tests_failed++;
            $display("FAIL errclr_race: lock_err=%b state=%0d expected 1 %0d", lock_err, state, ST_STBY);
        end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        tests_run++;
        if (lock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL errclr_plain: lock_err=%b expected 0", lock_err);
        end
    endtask

    task automatic test_ignored_pulses();
        int n;
        apply_reset();
        rand_cfg();
        pulse_start();
        wait_state(ST_WAIT, 100, n);
        step(5);
        pulse_start();
        relock = 1'b1;
        step(1);
        relock = 1'b0;
        tests_run++;
        if (state !== ST_WAIT || pll_stby !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_in_wait: state=%0d stby=%b expected %0d 0", state, pll_stby, ST_WAIT);
        end
        plock = 1'b1;
        wait_state(ST_SETTLE, 20, n);
        wait_state(ST_RUN, 400, n);
        tests_run++;
        if (n !== SETTLE_CYCLES + RST_DLY) begin
            tests_failed++;
            $display("FAIL ignore_settle_to_run: got %0d expected %0d", n, SETTLE_CYCLES + RST_DLY);
        end
        pulse_start();
        step(2);
        tests_run++;
        if (state !== ST_RUN) begin
            tests_failed++;
            $display("FAIL ignore_start_in_run: state=%0d expected %0d", state, ST_RUN);
        end
        start  = 1'b1;
        relock = 1'b1;
        step(1);
        start  = 1'b0;
        relock = 1'b0;
        tests_run++;
        if (state !== ST_STBY || lock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_and_relock: state=%0d lock_err=%b expected %0d 0", state, lock_err, ST_STBY);
        end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        rand_cfg();
        pulse_start();
        wait_state(ST_WAIT, 100, n);
        plock = 1'b1;
        wait_state(ST_SETTLE, 20, n);
        step(10);
        reset_l = 1'b0;
        #1;
        tests_run++;
        if (snap !== RESET_SNAP) begin
            tests_failed++;
            $display("FAIL async_reset_immediate: got %h expected %h", snap, RESET_SNAP);
        end
        step(1);
        reset_l = 1'b1;
        step(2);
        tests_run++;
        if (snap !== RESET_SNAP) begin
            tests_failed++;
            $display("FAIL async_reset_idle: got %h expected %h", snap, RESET_SNAP);
        end
    endtask

    task automatic test_random_bringup();
        int n;
        int d;
        for (int it = 0; it < 5; it++) begin
            apply_reset();
            rand_cfg();
            d = int'($urandom_range(0, 400));
            pulse_start();
            wait_state(ST_WAIT, 100, n);
            tests_run++;
            if (n !== STBY_CYCLES || {pll_m0, pll_n, pll_pa, pll_pb, pll_pc} !== exp_div) begin
                tests_failed++;
                $display("FAIL rand_stby it %0d: got %0d div=%h expected %0d div=%h",
                         it, n, {pll_m0, pll_n, pll_pa, pll_pb, pll_pc}, STBY_CYCLES, exp_div);
            end
            step(d);
            plock = 1'b1;
            wait_state(ST_RUN, 1000, n);
            tests_run++;
            if (n !== LOCK_REACT + SETTLE_CYCLES + RST_DLY) begin
                tests_failed++;
                $display("FAIL rand_lock_to_run it %0d (delay %0d): got %0d expected %0d",
                         it, d, n, LOCK_REACT + SETTLE_CYCLES + RST_DLY);
            end
            rand_cfg();
            relock = 1'b1;
            step(1);
            relock = 1'b0;
            tests_run++;
            if (state !== ST_STBY || {pll_m0, pll_n, pll_pa, pll_pb, pll_pc} !== exp_div) begin
                tests_failed++;
                $display("FAIL rand_relock_cfg it %0d: state=%0d div=%h expected %0d div=%h",
                         it, state, {pll_m0, pll_n, pll_pa, pll_pb, pll_pc}, ST_STBY, exp_div);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_settle_glitch();
        test_timeout();
        test_lock_loss_run();
        test_relock_cfg();
        test_ignored_pulses();
        test_async_reset();
        test_random_bringup();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
